// File: rtl/sccb_pkg.sv
// sccb_pkg: shared SCCB FSM states and default device ID.
package sccb_pkg;
    typedef enum logic [3:0] {
        IDLE, ID, ID_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } sccb_state_e;
    localparam logic [7:0] SCCB_DEFAULT_ID = 8'h60;
endpackage

// File: rtl/sccb_line_filter.sv
// sccb_line_filter: 2-flop sync, FILTER-cycle stability filter and edge pulses for one bus line.
module sccb_line_filter #(
    parameter int FILTER = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(FILTER + 1);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          prev;
    // Bus lines idle high through pull-ups, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync <= {sync[0], din};
            prev <= level;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
    assign rise = level & ~prev;
    assign fall = ~level & prev;
endmodule

// File: rtl/sccb_responder.sv
// sccb_responder: SCCB target decoding 3-phase/2-phase writes and 2-phase reads for a fixed ID.
module sccb_responder
    import sccb_pkg::*;
#(
    parameter logic [7:0] SID    = SCCB_DEFAULT_ID,
    parameter int         FILTER = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sioc,
    input  logic       siod_i,
    output logic       siod_oe,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       rd_req,
    output logic       busy
);
    sccb_state_e state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [7:0]  shift, shift_n, ptr, ptr_n, byte_in, wr_addr_n, wr_data_n;
    logic        rw, rw_n, oe_n, wr_en_n, rd_req_n;
    logic        scl, scl_rise, scl_fall, sda, sda_rise, sda_fall, start, stop;

    sccb_line_filter #(.FILTER(FILTER)) u_scl (
        .clk(clk), .rst_n(rst_n), .din(sioc), .level(scl), .rise(scl_rise), .fall(scl_fall)
    );
    sccb_line_filter #(.FILTER(FILTER)) u_sda (
        .clk(clk), .rst_n(rst_n), .din(siod_i), .level(sda), .rise(sda_rise), .fall(sda_fall)
    );

    assign start   = sda_fall & scl;
    assign stop    = sda_rise & scl;
    assign byte_in = {shift[6:0], sda};
    assign rd_addr = ptr;
    assign busy    = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            shift   <= '0;
            ptr     <= '0;
            rw      <= 1'b0;
            siod_oe <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            rd_req  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            shift   <= shift_n;
            ptr     <= ptr_n;
            rw      <= rw_n;
            siod_oe <= oe_n;
            wr_en   <= wr_en_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
            rd_req  <= rd_req_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shift_n   = rd_req ? rd_data : shift;
        ptr_n     = ptr;
        rw_n      = rw;
        oe_n      = siod_oe;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        rd_req_n  = 1'b0;
        if (stop) begin
            state_n = IDLE;
            oe_n    = 1'b0;
        end else if (start) begin
            state_n = ID;
            cnt_n   = '0;
            oe_n    = 1'b0;
        end else if (scl_rise) begin
            if (state inside {ID, ADDR, WDATA}) begin
                shift_n = byte_in;
                cnt_n   = cnt + 4'd1;
            end
            if (state == RDATA) cnt_n = cnt + 4'd1;
            // Pointer and write commit happen on the 8th sampled bit so an abort after it still counts.
            if (state == ADDR && cnt == 4'd7) ptr_n = byte_in;
            if (state == WDATA && cnt == 4'd7) begin
                wr_en_n   = 1'b1;
                wr_addr_n = ptr;
                wr_data_n = byte_in;
            end
        end else if (scl_fall) begin
            case (state)
                ID: if (cnt == 4'd8) begin
                    cnt_n = '0;
                    if (shift[7:1] == SID[7:1]) begin
                        state_n  = ID_ACK;
                        oe_n     = 1'b1;
                        rw_n     = shift[0];
                        rd_req_n = shift[0];
                    end else begin
                        state_n = IGNORE;
                    end
                end
                ADDR: if (cnt == 4'd8) begin
                    cnt_n   = '0;
                    state_n = ADDR_ACK;
                    oe_n    = 1'b1;
                end
                WDATA: if (cnt == 4'd8) begin
                    cnt_n   = '0;
                    state_n = WDATA_ACK;
                    oe_n    = 1'b1;
                end
                ID_ACK: begin
                    state_n = rw ? RDATA : ADDR;
                    oe_n    = rw ? ~shift[7] : 1'b0;
                    cnt_n   = '0;
                end
                ADDR_ACK: begin
                    state_n = WDATA;
                    oe_n    = 1'b0;
                end
                WDATA_ACK: begin
                    state_n = IGNORE;
                    oe_n    = 1'b0;
                end
                RDATA: if (cnt == 4'd8) begin
                    state_n = RDATA_ACK;
                    oe_n    = 1'b0;
                end else begin
                    oe_n    = ~shift[6];
                    shift_n = {shift[6:0], 1'b0};
                end
                RDATA_ACK: state_n = IGNORE;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sccb_responder.sv
// tb_sccb_responder: directed SCCB transactions against an open-drain bus model.
module tb_sccb_responder;
    localparam int H = 24;

    typedef struct {
        logic [31:0] bytes;
        int          n;
        logic [3:0]  acks;
        int          wr;
        logic [7:0]  wa;
        logic [7:0]  wd;
        logic [7:0]  ptr;
    } vec_t;

    logic       clk = 1'b0, rst_n = 1'b0, sioc = 1'b1, sda_m = 1'b1;
    logic [7:0] rd_data = 8'h26;
    logic       siod, siod_oe, wr_en, rd_req, busy;
    logic [7:0] wr_addr, wr_data, rd_addr;
    logic [7:0] last_wa = '0, last_wd = '0;
    int         tests = 0, fails = 0, wr_cnt = 0, rd_cnt = 0;
    vec_t       v[5];

    assign siod = sda_m & ~siod_oe;
    always #5 clk = ~clk;

    sccb_responder dut (
        .clk(clk), .rst_n(rst_n), .sioc(sioc), .siod_i(siod), .siod_oe(siod_oe),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_req(rd_req), .busy(busy)
    );

    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            last_wa = wr_addr;
            last_wd = wr_data;
        end
        if (rd_req) rd_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic start_c();
        sda_m = 1'b0;
        clks(H);
        sioc = 1'b0;
    endtask

    task automatic stop_c();
        clks(H / 2);
        sda_m = 1'b0;
        clks(H / 2);
        sioc = 1'b1;
        clks(H);
        sda_m = 1'b1;
        clks(H);
    endtask

    task automatic bit_c(input logic b, output logic bus);
        clks(H / 2);
        sda_m = b;
        clks(H / 2);
        sioc = 1'b1;
        clks(H / 2);
        bus = siod;
        clks(H / 2);
        sioc = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic x;
        for (int i = 7; i >= 0; i--) bit_c(b[i], x);
        bit_c(1'b1, x);
        ack = ~x;
    endtask

    task automatic recv_byte(output logic [7:0] val, output logic rel);
        logic x;
        for (int i = 7; i >= 0; i--) begin
            bit_c(1'b1, x);
            val[i] = x;
        end
        bit_c(1'b1, x);
        rel = x;
    endtask

    initial begin
        logic       a, rel;
        logic [7:0] rv;
        int         w0, r0;
        v[0] = '{32'h60FF0100, 3, 4'b1110, 1, 8'hFF, 8'h01, 8'hFF};
        v[1] = '{32'h42123400, 3, 4'b0000, 0, 8'h00, 8'h00, 8'hFF};
        v[2] = '{32'h600A0000, 2, 4'b1100, 0, 8'h00, 8'h00, 8'h0A};
        v[3] = '{32'h6010AA55, 4, 4'b1110, 1, 8'h10, 8'hAA, 8'h10};
        v[4] = '{32'h603C5A00, 3, 4'b1110, 1, 8'h3C, 8'h5A, 8'h3C};

        clks(3);
        chk("rst_oe", siod_oe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_rd_req", rd_req, 1'b0);
        chk("rst_rd_addr", rd_addr, 8'h00);
        chk("rst_wr_addr", wr_addr, 8'h00);
        chk("rst_wr_data", wr_data, 8'h00);
        rst_n = 1'b1;
        clks(10);

        for (int k = 0; k < 5; k++) begin
            w0 = wr_cnt;
            start_c();
            clks(10);
            chk($sformatf("v%0d_busy_start", k), busy, 1'b1);
            for (int i = 0; i < v[k].n; i++) begin
                send_byte(v[k].bytes[31 - 8 * i -: 8], a);
                chk($sformatf("v%0d_ack%0d", k, i), a, v[k].acks[3 - i]);
            end
            stop_c();
            chk($sformatf("v%0d_busy_stop", k), busy, 1'b0);
            chk($sformatf("v%0d_wr_count", k), wr_cnt - w0, v[k].wr);
            if (v[k].wr > 0) begin
                chk($sformatf("v%0d_wr_addr", k), last_wa, v[k].wa);
                chk($sformatf("v%0d_wr_data", k), last_wd, v[k].wd);
            end
            chk($sformatf("v%0d_ptr", k), rd_addr, v[k].ptr);
        end

        // 2-phase pointer set followed by a read of 0x26
        w0 = wr_cnt;
        start_c();
        send_byte(8'h60, a);
        send_byte(8'h0A, a);
        stop_c();
        r0 = rd_cnt;
        start_c();
        send_byte(8'h61, a);
        chk("rd_id_ack", a, 1'b1);
        chk("rd_req_once", rd_cnt - r0, 1);
        recv_byte(rv, rel);
        chk("rd_byte", rv, 8'h26);
        chk("rd_nack_released", rel, 1'b1);
        stop_c();
        chk("rd_ptr", rd_addr, 8'h0A);
        chk("rd_no_write", wr_cnt - w0, 0);
        chk("rd_busy_stop", busy, 1'b0);

        // STOP after 4 address bits, then sub-FILTER glitches on both lines
        w0 = wr_cnt;
        start_c();
        send_byte(8'h60, a);
        chk("ab_id_ack", a, 1'b1);
        bit_c(1'b1, a);
        bit_c(1'b0, a);
        bit_c(1'b1, a);
        bit_c(1'b0, a);
        stop_c();
        chk("ab_no_write", wr_cnt - w0, 0);
        chk("ab_ptr", rd_addr, 8'h0A);
        chk("ab_idle", busy, 1'b0);
        sioc = 1'b0;
        clks(2);
        sioc = 1'b1;
        clks(20);
        chk("glitch_scl_idle", busy, 1'b0);
        sda_m = 1'b0;
        clks(2);
        sda_m = 1'b1;
        clks(20);
        chk("glitch_sda_idle", busy, 1'b0);

        // Reset while driving read bit 7 (0) low
        start_c();
        send_byte(8'h61, a);
        chk("rr_id_ack", a, 1'b1);
        clks(12);
        chk("rr_oe_before", siod_oe, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rr_oe_async", siod_oe, 1'b0);
        chk("rr_busy", busy, 1'b0);
        chk("rr_rd_req", rd_req, 1'b0);
        chk("rr_wr_en", wr_en, 1'b0);
        chk("rr_rd_addr", rd_addr, 8'h00);
        chk("rr_wr_addr", wr_addr, 8'h00);
        chk("rr_wr_data", wr_data, 8'h00);
        sda_m = 1'b1;
        sioc = 1'b1;
        clks(3);
        rst_n = 1'b1;
        clks(10);
        w0 = wr_cnt;
        start_c();
        send_byte(8'h60, a);
        chk("pr_ack0", a, 1'b1);
        send_byte(8'h77, a);
        chk("pr_ack1", a, 1'b1);
        send_byte(8'h88, a);
        chk("pr_ack2", a, 1'b1);
        stop_c();
        chk("pr_wr_count", wr_cnt - w0, 1);
        chk("pr_wr_addr", last_wa, 8'h77);
        chk("pr_wr_data", last_wd, 8'h88);
        chk("pr_ptr", rd_addr, 8'h77);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sccb_responder.md
# sccb_responder

SCCB/I2C-compatible target (responder) for the camera configuration bus. It decodes 3-phase write, 2-phase write and 2-phase read transactions addressed to a fixed slave ID. Writes go to an external 8-bit register file, and reads return that file's contents. It sits behind the FPGA pins as an OV2640 register-map stand-in for loopback bring-up, and as the bus-level checker for the camera controller's SCCB initiator.

## Interface
- SID, 8'h60: 8-bit write ID; the read ID is SID|1. Only SID[7:1] is compared.
- FILTER, 3: glitch-filter length in clk cycles; a line level must be stable this long to be accepted.
- clk  in  1  system clock (50 MHz nominal)
- rst_n  in  1  reset; one clock, asynchronous assert, active-low
- sioc  in  1  SCCB clock from initiator
- siod_i  in  1  SCCB data as seen on pin
- siod_oe  out  1  1 = pull siod low (open-drain); data is never driven high
- wr_en  out  1  one-clk write strobe
- wr_addr  out  8  register sub-address for write
- wr_data  out  8  write data
- rd_addr  out  8  current sub-address pointer, used for reads
- rd_data  in  8  register contents at rd_addr; sampled one clk after rd_req
- rd_req  out  1  one-clk pulse requesting a read byte
- busy  out  1  high from START to STOP

## Operation
- sioc and siod_i each pass through a 2-flop synchronizer, then a FILTER-cycle stability filter, then rise/fall edge detection.
- START: filtered siod falls while sioc is high. It is accepted in any state, including a repeated start, and goes to ID.
- STOP: filtered siod rises while sioc is high. It goes to IDLE from any state and releases siod_oe.
- Bits are sampled MSB first on sioc rise. Outputs change only on sioc fall.
- States and transitions:
  - IDLE: wait for START.
  - ID: 8 bits. On match, go to ID_ACK. On mismatch, go to IGNORE (no ack).
  - ID_ACK: go to ADDR if R/W=0, or to RDATA if R/W=1.
  - ADDR: 8 bits into the pointer (rd_addr), then ADDR_ACK, then WDATA.
  - WDATA: 8 bits, then WDATA_ACK, then IGNORE. Extra bytes get no ack and are not written; there is no auto-increment.
  - RDATA: 8 bits out, then RDATA_ACK (master ack/nack is sampled and ignored), then IGNORE.
  - IGNORE: wait for START or STOP.
- ACK: siod_oe=1 from the sioc fall after bit 8 until the sioc fall after bit 9.
- Write commit: wr_en pulses for 1 clk, 1 clk after the 8th WDATA bit is sampled, with wr_addr=pointer and wr_data=byte. The pointer is unchanged.
- A 2-phase write (ID, ADDR, STOP) only updates the pointer. The pointer persists across transactions.
- Read: rd_req pulses on entry to ID_ACK with R/W=1. rd_data is latched into the shift register 1 clk later. Bit 7 is presented at the sioc fall that ends ID_ACK. siod_oe = ~bit.
- Reset: state IDLE; siod_oe, wr_en, rd_req, busy = 0; wr_addr, wr_data, rd_addr = 8'h00.

## Timing
- Input latency: 2 sync + FILTER + 1 edge = 6 clk at defaults.
- Requirement: sioc high and low phases must each be ≥ 2×(FILTER+3) clk. siod must be stable ≥ FILTER+3 clk around sioc edges. At 50 MHz this supports up to 400 kHz.
- siod_oe changes ≤ FILTER+4 clk after the physical sioc fall, inside the low phase.
- Reset mid-transfer forces siod_oe=0 asynchronously. No wr_en is issued for the partial transaction.
- STOP or START mid-byte aborts the byte: no wr_en, and the pointer is not updated unless all 8 address bits were received.
- A pulse on either line shorter than FILTER clk is ignored entirely.

## Structure
- Package sccb_pkg: state enum (IDLE, ID, ID_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE) and the default-ID constant 8'h60 shared with the initiator.
- Sub-module sccb_line_filter: synchronizer, stability filter and rise/fall pulses. It is instantiated for sioc and for siod.
- Top level contents: FSM, 4-bit bit counter, 8-bit shift register, pointer register.

## Test plan
- 3-phase write: ID 0x60, addr 0xFF, data 0x01, STOP → exactly one wr_en with wr_addr=0xFF, wr_data=0x01; siod low in all three ack slots; busy drops after STOP.
- Wrong ID 0x42, addr 0x12, data 0x34 → no ack at any slot, no wr_en, pointer unchanged, IDLE after STOP.
- 2-phase write 0x60/0x0A, STOP, then read 0x61 with rd_data=0x26 → rd_addr=0x0A, rd_req once, bus bits 0,0,1,0,0,1,1,0, siod released at master nack.
- Extra byte: ID 0x60, addr 0x10, data 0xAA, data 0x55 → single wr_en (0x10, 0xAA), no ack on fourth byte.
- Abort: STOP after 4 address bits, then a 2-cycle glitch on sioc → no wr_en, pointer unchanged, state IDLE.
- rst_n low during RDATA while siod_oe=1 → siod_oe=0 in the same cycle; all outputs at reset values; the next full write succeeds.
